// File: rtl/seq_mac_unit.sv
// Sequential unsigned shift-and-add multiplier feeding a wrap-around accumulator.
// One multiplier bit is consumed per clock; start/busy/done handshake.
module seq_mac_unit #(
  parameter int WIDTH = 8,
  parameter int ACC_W = 2*WIDTH+4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic               acc_en,
  input  logic               clear_acc,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] p,
  output logic [ACC_W-1:0]   acc,
  output logic               ovf
);

  localparam int PW = 2*WIDTH;
  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH-1);

  typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;

  state_t           state_reg;
  logic [PW-1:0]    a_sh_reg;
  logic [PW-1:0]    pp_reg;
  logic [WIDTH-1:0] b_sh_reg;
  logic [CW-1:0]    cnt_reg;
  logic             en_reg;

  logic [PW-1:0]    pp_next;
  logic [ACC_W:0]   sum_next;

  // The partial product including the current bit; on the last MUL edge this is the full product.
  always_comb begin
    pp_next  = b_sh_reg[0] ? (pp_reg + a_sh_reg) : pp_reg;
    sum_next = {1'b0, acc} + {{(ACC_W+1-PW){1'b0}}, pp_next};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      a_sh_reg  <= '0;
      b_sh_reg  <= '0;
      pp_reg    <= '0;
      cnt_reg   <= '0;
      en_reg    <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      p         <= '0;
      acc       <= '0;
      ovf       <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          done <= 1'b0;
          if (clear_acc) begin
            acc <= '0;
            ovf <= 1'b0;
          end
          if (start) begin
            a_sh_reg  <= {{WIDTH{1'b0}}, a};
            b_sh_reg  <= b;
            en_reg    <= acc_en;
            pp_reg    <= '0;
            cnt_reg   <= '0;
            busy      <= 1'b1;
            state_reg <= MUL;
          end
        end
        MUL: begin
          pp_reg   <= pp_next;
          a_sh_reg <= a_sh_reg << 1;
          b_sh_reg <= b_sh_reg >> 1;
          cnt_reg  <= cnt_reg + 1'b1;
          if (cnt_reg == LAST) begin
            p <= pp_next;
            if (en_reg) begin
              acc <= sum_next[ACC_W-1:0];
              // Sticky: only a clear or reset drops it.
              ovf <= ovf | sum_next[ACC_W];
            end
            busy      <= 1'b0;
            done      <= 1'b1;
            state_reg <= DONE;
          end
        end
        DONE: begin
          done      <= 1'b0;
          state_reg <= IDLE;
        end
        default: begin
          busy      <= 1'b0;
          done      <= 1'b0;
          state_reg <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_mac_unit.sv
// Randomized scoreboard bench for seq_mac_unit (WIDTH=8, ACC_W=20) plus a WIDTH=3 regression instance.
module tb_seq_mac_unit;

  localparam int W  = 8;
  localparam int AW = 20;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          start = 1'b0, acc_en = 1'b0, clear_acc = 1'b0;
  logic [W-1:0]  a = '0, b = '0;
  logic          busy, done, ovf;
  logic [2*W-1:0] p;
  logic [AW-1:0] acc;

  logic          start3 = 1'b0;
  logic [2:0]    a3 = '0, b3 = '0;
  logic          busy3, done3, ovf3;
  logic [5:0]    p3;
  logic [9:0]    acc3;

  seq_mac_unit #(.WIDTH(W), .ACC_W(AW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .acc_en(acc_en),
    .clear_acc(clear_acc), .busy(busy), .done(done), .p(p), .acc(acc), .ovf(ovf)
  );

  seq_mac_unit #(.WIDTH(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .start(start3), .a(a3), .b(b3), .acc_en(1'b0),
    .clear_acc(1'b0), .busy(busy3), .done(done3), .p(p3), .acc(acc3), .ovf(ovf3)
  );

  int tests = 0;
  int fails = 0;
  longint cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    longint p;
    longint acc;
    longint ovf;
    longint when;
  } exp_t;
  exp_t sb[$];

  longint acc_m = 0;
  longint ovf_m = 0;
  localparam longint MOD = 64'd1 << AW;

  task automatic check(input string name, input longint act, input longint expv);
    tests++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, expv, $time);
    end
  endtask

  task automatic fail_now(input string name);
    tests++;
    fails++;
    $display("FAIL %s: got timeout expected completion (t=%0t)", name, $time);
  endtask

  // Reference: product is exact, accumulator is a modulo-2^AW sum with a sticky carry flag.
  function automatic void model(input longint av, input longint bv, input bit en,
                                input bit clr, input longint when);
    longint prod, s;
    exp_t e;
    if (clr) begin
      acc_m = 0;
      ovf_m = 0;
    end
    prod = av * bv;
    if (en) begin
      s = acc_m + prod;
      if (s >= MOD) ovf_m = 1;
      acc_m = s % MOD;
    end
    e.p = prod; e.acc = acc_m; e.ovf = ovf_m; e.when = when;
    sb.push_back(e);
  endfunction

  // Monitor: compare every done pulse against the oldest expected result.
  logic done_q = 1'b0;
  always @(posedge clk) done_q <= done;

  always @(negedge clk) begin
    if (rst_n && done) begin
      if (done_q) check("done_width", 2, 1);
      if (sb.size() == 0) begin
        check("unexpected_done", 1, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("p", longint'(p), e.p);
        check("acc", longint'(acc), e.acc);
        check("ovf", longint'(ovf), e.ovf);
        check("latency_cycle", cyc, e.when);
      end
    end
  end

  task automatic wait_idle();
    int n = 0;
    while ((busy || done) && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) fail_now("wait_idle");
  endtask

  task automatic do_op(input int av, input int bv, input bit en, input bit clr);
    wait_idle();
    a = W'(av); b = W'(bv); acc_en = en; clear_acc = clr; start = 1'b1;
    model(av, bv, en, clr, cyc + 1 + W);
    @(negedge clk);
    start = 1'b0; clear_acc = 1'b0;
    a = W'($urandom_range(0, 255)); b = W'($urandom_range(0, 255)); acc_en = $urandom_range(0, 1) != 0;
  endtask

  task automatic clear_only();
    wait_idle();
    clear_acc = 1'b1;
    @(negedge clk);
    clear_acc = 1'b0;
    acc_m = 0; ovf_m = 0;
    check("clear_acc", longint'(acc), 0);
    check("clear_ovf", longint'(ovf), 0);
  endtask

  int va[6] = '{1, 2, 3, 4, 5, 6};
  int vb[6] = '{1, 1, 2, 4, 2, 1};
  int vp[6] = '{1, 2, 6, 16, 10, 6};

  initial begin
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    check("rst_p", longint'(p), 0);
    check("rst_acc", longint'(acc), 0);
    check("rst_ovf", longint'(ovf), 0);
    check("rst_busy", longint'(busy), 0);
    check("rst_done", longint'(done), 0);

    // Single op 3*2 with accumulate.
    do_op(3, 2, 1, 0);
    check("single_busy", longint'(busy), 1);
    wait_idle();
    check("single_p", longint'(p), 6);
    check("single_acc", longint'(acc), 6);

    // WIDTH=3 regression vectors, acc_en tied low.
    for (int i = 0; i < 6; i++) begin
      int n;
      a3 = 3'(va[i]); b3 = 3'(vb[i]); start3 = 1'b1;
      @(negedge clk);
      start3 = 1'b0;
      n = 0;
      while (!done3 && n < 20) begin
        @(negedge clk);
        n++;
      end
      if (n >= 20) fail_now("w3_done");
      check("w3_p", longint'(p3), vp[i]);
      check("w3_acc", longint'(acc3), 0);
      @(negedge clk);
    end

    // Overflow sequence.
    clear_only();
    for (int i = 0; i < 16; i++) do_op(255, 255, 1, 0);
    wait_idle();
    check("ovf16_acc", longint'(acc), 1040400);
    check("ovf16_ovf", longint'(ovf), 0);
    do_op(255, 255, 1, 0);
    wait_idle();
    check("ovf17_acc", longint'(acc), 56849);
    check("ovf17_ovf", longint'(ovf), 1);
    clear_only();

    // Simultaneous clear and start.
    do_op(10, 10, 1, 1);
    wait_idle();
    check("pre_clr_acc", longint'(acc), 100);
    do_op(7, 9, 1, 1);
    wait_idle();
    check("clrstart_p", longint'(p), 63);
    check("clrstart_acc", longint'(acc), 63);

    // Start held high with operands changing every cycle; accepts land every W+2 cycles.
    for (int op = 0; op < 5; op++) begin
      for (int i = 0; i < W + 2; i++) begin
        a = W'($urandom_range(0, 255)); b = W'($urandom_range(0, 255));
        acc_en = $urandom_range(0, 1) != 0;
        if (i == 0) begin
          start = 1'b1;
          model(longint'(a), longint'(b), acc_en, 1'b0, cyc + 1 + W);
        end
        check("hs_busy", longint'(busy), (i >= 1 && i <= W) ? 1 : 0);
        @(negedge clk);
      end
    end
    start = 1'b0;
    wait_idle();

    // Random operations with occasional clears.
    for (int i = 0; i < 30; i++)
      do_op($urandom_range(0, 255), $urandom_range(0, 255),
            $urandom_range(0, 1) != 0, $urandom_range(0, 7) == 0);
    wait_idle();

    // Reset during MUL: outputs drop at once and the aborted op never completes.
    do_op(200, 201, 1, 0);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("abort_p", longint'(p), 0);
    check("abort_acc", longint'(acc), 0);
    check("abort_ovf", longint'(ovf), 0);
    check("abort_busy", longint'(busy), 0);
    check("abort_done", longint'(done), 0);
    sb.delete();
    acc_m = 0; ovf_m = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    do_op(5, 5, 1, 0);
    wait_idle();
    check("post_rst_p", longint'(p), 25);
    check("post_rst_acc", longint'(acc), 25);

    begin
      int n = 0;
      while (sb.size() > 0 && n < 100) begin
        @(negedge clk);
        n++;
      end
      if (sb.size() > 0) fail_now("scoreboard_drain");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
